// File: rtl/dot_tracker.sv
// Pellet tilemap, score and level-progress tracker feeding the renderer's dot layer.
// Optional BIG_DOT_EN adds four corner power pellets, tilemap_big_dots and power_active.
module dot_tracker #(
  parameter int TILE_ROWS  = 15,
  parameter int TILE_COLS  = 20,
  parameter int TILE_LOG2  = 5,
  parameter int X_W        = 10,
  parameter int Y_W        = 9,
  parameter int SCORE_W    = 16,
  parameter int DOT_POINTS = 10,
`ifdef BIG_DOT_EN
  parameter int BIG_POINTS  = 50,
  parameter int POWER_TICKS = 500,
`endif
  localparam int N     = TILE_ROWS * TILE_COLS,
  localparam int IDX_W = $clog2(N + 1)
) (
  input  logic               clk_25MHz,
  input  logic               reset,
  input  logic               game_tick,
  input  logic               restart,
  input  logic [X_W-1:0]     player_x,
  input  logic [Y_W-1:0]     player_y,
  input  logic [N-1:0]       tilemap_walls,
  output logic [N-1:0]       tilemap_dots,
  output logic [SCORE_W-1:0] score,
  output logic [IDX_W-1:0]   dots_left,
  output logic               eat_pulse,
  output logic               level_clear,
`ifdef BIG_DOT_EN
  output logic [N-1:0]       tilemap_big_dots,
  output logic               power_active,
`endif
  output logic [1:0]         fsm_state
);

  typedef enum logic [1:0] {FILL = 2'd0, PLAY = 2'd1, DONE = 2'd2} state_t;

  localparam int HALF = 1 << (TILE_LOG2 - 1);

  state_t           state;
  logic [IDX_W-1:0] fill_idx;
  logic [X_W:0]     cx;
  logic [Y_W:0]     cy;
  logic [X_W-TILE_LOG2:0] col;
  logic [Y_W-TILE_LOG2:0] row;
  logic             in_range;
  logic [IDX_W-1:0] tile_idx;
  logic             hit_small;
  logic             hit_big;
  logic             fill_small;
  logic             fill_big;
  logic [IDX_W-1:0] fill_left;
  logic             fill_last;
  logic [SCORE_W:0] score_sum;
  logic [SCORE_W-1:0] score_next;

  assign fsm_state = state;

  // Player centre is sprite top-left plus half a tile; one extra bit keeps the sum from wrapping.
  assign cx  = {1'b0, player_x} + (X_W + 1)'(HALF);
  assign cy  = {1'b0, player_y} + (Y_W + 1)'(HALF);
  assign col = cx[X_W:TILE_LOG2];
  assign row = cy[Y_W:TILE_LOG2];

  always_comb begin
    in_range = (int'(col) < TILE_COLS) && (int'(row) < TILE_ROWS);
    tile_idx = '0;
    if (in_range) tile_idx = IDX_W'(int'(row) * TILE_COLS + int'(col));
  end

`ifdef BIG_DOT_EN
  localparam logic [IDX_W-1:0] BIG_A = IDX_W'(1 * TILE_COLS + 1);
  localparam logic [IDX_W-1:0] BIG_B = IDX_W'(1 * TILE_COLS + TILE_COLS - 2);
  localparam logic [IDX_W-1:0] BIG_C = IDX_W'((TILE_ROWS - 2) * TILE_COLS + 1);
  localparam logic [IDX_W-1:0] BIG_D = IDX_W'((TILE_ROWS - 2) * TILE_COLS + TILE_COLS - 2);
  localparam int PWR_W = $clog2(POWER_TICKS + 1);

  logic [PWR_W-1:0] power_cnt;
  logic             big_tile;

  assign big_tile     = (fill_idx == BIG_A) || (fill_idx == BIG_B) ||
                        (fill_idx == BIG_C) || (fill_idx == BIG_D);
  assign fill_big     = ~tilemap_walls[fill_idx] & big_tile;
  assign fill_small   = ~tilemap_walls[fill_idx] & ~big_tile;
  assign hit_big      = in_range && tilemap_big_dots[tile_idx];
  assign power_active = (power_cnt != '0);
`else
  assign fill_big   = 1'b0;
  assign fill_small = ~tilemap_walls[fill_idx];
  assign hit_big    = 1'b0;
`endif

  assign hit_small = in_range && tilemap_dots[tile_idx];
  assign fill_left = dots_left + IDX_W'(fill_small | fill_big);
  assign fill_last = (fill_idx == IDX_W'(N - 1));

  always_comb begin
    score_sum = {1'b0, score} + (SCORE_W + 1)'(DOT_POINTS);
`ifdef BIG_DOT_EN
    if (hit_big) score_sum = {1'b0, score} + (SCORE_W + 1)'(BIG_POINTS);
`endif
    score_next = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
  end

  always_ff @(posedge clk_25MHz or negedge reset) begin
    if (!reset) begin
      state        <= FILL;
      fill_idx     <= '0;
      tilemap_dots <= '0;
      score        <= '0;
      dots_left    <= '0;
      eat_pulse    <= 1'b0;
      level_clear  <= 1'b0;
`ifdef BIG_DOT_EN
      tilemap_big_dots <= '0;
      power_cnt        <= '0;
`endif
    end else begin
      eat_pulse <= 1'b0;
      // Registered from state, so it rises one cycle after the edge that enters DONE.
      level_clear <= (state == DONE);
      if (restart) begin
        state        <= FILL;
        fill_idx     <= '0;
        tilemap_dots <= '0;
        dots_left    <= '0;
        level_clear  <= 1'b0;
`ifdef BIG_DOT_EN
        tilemap_big_dots <= '0;
        power_cnt        <= '0;
`endif
      end else begin
        case (state)
          FILL: begin
            tilemap_dots[fill_idx] <= fill_small;
`ifdef BIG_DOT_EN
            tilemap_big_dots[fill_idx] <= fill_big;
`endif
            dots_left <= fill_left;
            if (fill_last) begin
              fill_idx <= '0;
              state    <= (fill_left == '0) ? DONE : PLAY;
            end else begin
              fill_idx <= fill_idx + 1'b1;
            end
          end
          PLAY: begin
            if (game_tick) begin
`ifdef BIG_DOT_EN
              if (hit_big) power_cnt <= PWR_W'(POWER_TICKS);
              else if (power_cnt != '0) power_cnt <= power_cnt - 1'b1;
              if (hit_big) tilemap_big_dots[tile_idx] <= 1'b0;
`endif
              if (hit_small || hit_big) begin
                tilemap_dots[tile_idx] <= 1'b0;
                score     <= score_next;
                dots_left <= dots_left - 1'b1;
                eat_pulse <= 1'b1;
                if (dots_left == IDX_W'(1)) state <= DONE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
